// File: rtl/proj_scheduler.sv
// Token sequencer for the QKV projection unit: fetch, start, feed, wait, then Q/K/V writeback beats.
// Optional WAIT-state watchdog enabled by defining PROJ_TIMEOUT_EN.
module proj_scheduler #(
   parameter int MAX_TOK = 128,
   parameter int AW      = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [AW-1:0] cmd_len,
   input  logic          abort,
   output logic          tok_rd_en,
   output logic [AW-1:0] tok_rd_addr,
   input  logic          tok_rd_valid,
   output logic          proj_start,
   output logic          proj_in_valid,
   input  logic          proj_out_valid,
   output logic          wb_valid,
   input  logic          wb_ready,
   output logic [1:0]    wb_sel,
   output logic [AW-1:0] wb_addr,
   output logic          busy,
   output logic          done,
   output logic          err
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_RDWAIT, S_ISSUE, S_FEED, S_WAIT, S_WRITE, S_DONE
   } state_t;

   localparam logic [AW-1:0] ONE = AW'(1);

   state_t        state;
   logic [AW-1:0] tok_idx;
   logic [AW-1:0] len_q;
   logic          last_tok;

   // Configurations where AW cannot index MAX_TOK tokens elaborate this empty scope.
   if (MAX_TOK >= (1 << AW) || TIMEOUT < 2) begin : g_bad_cfg
   end

`ifdef PROJ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tmo_cnt;
`endif

   assign last_tok = (tok_idx == len_q - ONE);

   // Outputs are set on the transition into the state they belong to, so they are
   // registered yet line up cycle-for-cycle with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         cmd_ready     <= 1'b1;
         busy          <= 1'b0;
         tok_rd_en     <= 1'b0;
         tok_rd_addr   <= '0;
         proj_start    <= 1'b0;
         proj_in_valid <= 1'b0;
         wb_valid      <= 1'b0;
         wb_sel        <= 2'd0;
         wb_addr       <= '0;
         done          <= 1'b0;
         err           <= 1'b0;
         tok_idx       <= '0;
         len_q         <= '0;
`ifdef PROJ_TIMEOUT_EN
         tmo_cnt       <= '0;
`endif
      end else begin
         tok_rd_en     <= 1'b0;
         proj_start    <= 1'b0;
         proj_in_valid <= 1'b0;
         done          <= 1'b0;
         if (abort) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            wb_valid  <= 1'b0;
            wb_sel    <= 2'd0;
            tok_idx   <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (cmd_valid && cmd_ready) begin
                     len_q     <= cmd_len;
                     tok_idx   <= '0;
                     err       <= 1'b0;
                     cmd_ready <= 1'b0;
                     busy      <= 1'b1;
                     if (cmd_len == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                     end else begin
                        state       <= S_FETCH;
                        tok_rd_en   <= 1'b1;
                        tok_rd_addr <= '0;
                     end
                  end
               end
               S_FETCH: state <= S_RDWAIT;
               S_RDWAIT: begin
                  if (tok_rd_valid) begin
                     state      <= S_ISSUE;
                     proj_start <= 1'b1;
                  end
               end
               S_ISSUE: begin
                  state         <= S_FEED;
                  proj_in_valid <= 1'b1;
               end
               S_FEED: begin
                  state <= S_WAIT;
`ifdef PROJ_TIMEOUT_EN
                  tmo_cnt <= '0;
`endif
               end
               S_WAIT: begin
                  if (proj_out_valid) begin
                     state    <= S_WRITE;
                     wb_valid <= 1'b1;
                     wb_sel   <= 2'd0;
                     wb_addr  <= tok_idx;
                  end
`ifdef PROJ_TIMEOUT_EN
                  else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                     err   <= 1'b1;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     tmo_cnt <= tmo_cnt + 1'b1;
                  end
`endif
               end
               S_WRITE: begin
                  if (wb_ready) begin
                     if (wb_sel == 2'd2) begin
                        wb_valid <= 1'b0;
                        wb_sel   <= 2'd0;
                        if (last_tok) begin
                           state <= S_DONE;
                           done  <= 1'b1;
                        end else begin
                           tok_idx     <= tok_idx + ONE;
                           tok_rd_addr <= tok_idx + ONE;
                           tok_rd_en   <= 1'b1;
                           state       <= S_FETCH;
                        end
                     end else begin
                        wb_sel <= wb_sel + 2'd1;
                     end
                  end
               end
               S_DONE: begin
                  state     <= S_IDLE;
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_proj_scheduler.sv
// Scoreboard bench for proj_scheduler: stimulus pushes expected reads/beats/done into queues,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_proj_scheduler;
   localparam int AW  = 8;
   localparam int TMO = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic [AW-1:0] cmd_len = '0;
   logic          abort = 1'b0;
   logic          tok_rd_valid = 1'b0;
   logic          proj_out_valid = 1'b0;
   logic          wb_ready = 1'b1;
   logic          cmd_ready, tok_rd_en, proj_start, proj_in_valid, wb_valid, busy, done, err;
   logic [AW-1:0] tok_rd_addr, wb_addr;
   logic [1:0]    wb_sel;

   proj_scheduler #(.MAX_TOK(128), .AW(AW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_len(cmd_len), .abort(abort), .tok_rd_en(tok_rd_en), .tok_rd_addr(tok_rd_addr),
      .tok_rd_valid(tok_rd_valid), .proj_start(proj_start), .proj_in_valid(proj_in_valid),
      .proj_out_valid(proj_out_valid), .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_sel(wb_sel), .wb_addr(wb_addr), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0;
   int rd_q[$], wb_q[$], done_q[$];
   int n_rd = 0, n_start = 0, n_inv = 0, n_wb = 0, n_done = 0, n_holdk = 0;
   int out_lat = 5;
   bit drop_out = 1'b0;
   int inj_idle_req = 0, inj_feed_req = 0, stall_req = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input int len);
      for (int t = 0; t < len; t++) begin
         rd_q.push_back(t);
         for (int s = 0; s < 3; s++) wb_q.push_back(s * 256 + t);
      end
      done_q.push_back(0);
   endtask

   task automatic send(input int len);
      chk("cmd_ready_pre", int'(cmd_ready), 1);
      cmd_valid = 1'b1;
      cmd_len   = len[AW-1:0];
      tick();
      cmd_valid = 1'b0;
      chk("busy_after_accept", int'(busy), 1);
   endtask

   task automatic wait_idle(input int bound, input string nm);
      int i = 0;
      while (busy && i < bound) begin
         tick();
         i++;
      end
      chk(nm, int'(busy), 0);
   endtask

   task automatic wait_inv(input int cnt, input string nm);
      int seen = 0, i = 0;
      while (seen < cnt && i < 200) begin
         tick();
         i++;
         if (proj_in_valid) seen++;
      end
      chk(nm, seen, cnt);
   endtask

   task automatic q_empty(input string nm);
      chk({nm, "_rd_left"}, rd_q.size(), 0);
      chk({nm, "_wb_left"}, wb_q.size(), 0);
      chk({nm, "_done_left"}, done_q.size(), 0);
   endtask

   // Environment model: token buffer, projection unit and writeback sink.
   initial begin
      int ov_cnt = 0, stall = 0;
      int idle_done = 0, feed_done = 0, stall_done = 0;
      bit rd_pend = 1'b0;
      forever begin
         tick();
         if (!rst_n) begin
            tok_rd_valid = 1'b0; proj_out_valid = 1'b0; wb_ready = 1'b1;
            ov_cnt = 0; rd_pend = 1'b0; stall = 0;
            continue;
         end
         tok_rd_valid = rd_pend;
         rd_pend = tok_rd_en;
         proj_out_valid = 1'b0;
         if (ov_cnt > 0) begin
            ov_cnt--;
            if (ov_cnt == 0) proj_out_valid = 1'b1;
         end
         if (proj_in_valid && !drop_out) ov_cnt = out_lat;
         if (feed_done < inj_feed_req && proj_in_valid) begin
            proj_out_valid = 1'b1;
            feed_done++;
         end
         if (idle_done < inj_idle_req && cmd_ready) begin
            proj_out_valid = 1'b1;
            idle_done++;
         end
         if (stall_done < stall_req && wb_valid && wb_sel == 2'd1 && wb_addr == '0) begin
            stall = 4;
            stall_done++;
         end
         wb_ready = (stall == 0);
         if (stall > 0) stall--;
      end
   end

   // Monitor / scoreboard.
   initial begin
      bit hold = 1'b0;
      int psel = 0, paddr = 0, act = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold = 1'b0;
            continue;
         end
         if (proj_start || proj_in_valid)
            chk("start_inv_overlap", int'(proj_start && proj_in_valid), 0);
         if (proj_start) n_start++;
         if (proj_in_valid) n_inv++;
         if (tok_rd_en) begin
            n_rd++;
            if (rd_q.size() == 0) chk("rd_unexpected", int'(tok_rd_addr), -1);
            else chk("rd_addr", int'(tok_rd_addr), rd_q.pop_front());
         end
         if (hold) begin
            chk("wb_hold_valid", int'(wb_valid), 1);
            chk("wb_hold_sel", int'(wb_sel), psel);
            chk("wb_hold_addr", int'(wb_addr), paddr);
         end
         hold  = wb_valid && !wb_ready;
         psel  = int'(wb_sel);
         paddr = int'(wb_addr);
         if (wb_valid && wb_sel == 2'd1 && wb_addr == '0) n_holdk++;
         if (wb_valid && wb_ready) begin
            n_wb++;
            act = int'(wb_sel) * 256 + int'(wb_addr);
            if (wb_q.size() == 0) chk("wb_unexpected", act, -1);
            else chk("wb_beat", act, wb_q.pop_front());
         end
         if (done) begin
            n_done++;
            if (done_q.size() == 0) chk("done_unexpected", 1, 0);
            else chk("done_err", int'(err), done_q.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1);
   end

   initial begin
      int r0, w0, d0, s0, i, k, bad;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", int'(cmd_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_wb_valid", int'(wb_valid), 0);
      chk("rst_rd_en", int'(tok_rd_en), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_wb_sel", int'(wb_sel), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();

      // 1: three tokens, no stalls
      r0 = n_rd; w0 = n_wb; d0 = n_done;
      push_cmd(3);
      send(3);
      wait_idle(300, "t1_finish");
      chk("t1_rd_count", n_rd - r0, 3);
      chk("t1_wb_count", n_wb - w0, 9);
      chk("t1_done_count", n_done - d0, 1);
      chk("t1_err", int'(err), 0);
      q_empty("t1");

      // 2: zero-length command
      r0 = n_rd; s0 = n_start; d0 = n_done;
      done_q.push_back(0);
      send(0);
      i = 0;
      while (!done && i < 4) begin
         tick();
         i++;
      end
      chk("t2_done_seen", int'(done), 1);
      chk("t2_done_window", int'(i <= 1), 1);
      tick();
      chk("t2_ready_back", int'(cmd_ready), 1);
      chk("t2_rd_count", n_rd - r0, 0);
      chk("t2_start_count", n_start - s0, 0);
      chk("t2_done_count", n_done - d0, 1);
      q_empty("t2");

      // 3: K beat of token 0 stalled by the sink
      w0 = n_wb; n_holdk = 0;
      stall_req++;
      push_cmd(2);
      send(2);
      wait_idle(300, "t3_finish");
      chk("t3_k_hold_cycles", n_holdk, 5);
      chk("t3_wb_count", n_wb - w0, 6);
      q_empty("t3");

      // 4: abort during WAIT of token 1, then a normal one-token command
      d0 = n_done;
      rd_q.push_back(0); rd_q.push_back(1);
      for (int s = 0; s < 3; s++) wb_q.push_back(s * 256);
      send(4);
      wait_inv(2, "t4_reach_feed");
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t4_busy", int'(busy), 0);
      chk("t4_cmd_ready", int'(cmd_ready), 1);
      chk("t4_wb_valid", int'(wb_valid), 0);
      repeat (10) tick();
      chk("t4_no_done", n_done - d0, 0);
      q_empty("t4_abort");
      push_cmd(1);
      send(1);
      wait_idle(200, "t4_finish");
      chk("t4_done_count", n_done - d0, 1);
      q_empty("t4_after");

      // 5: spurious out_valid in IDLE and in FEED
      w0 = n_wb;
      inj_idle_req++;
      repeat (3) tick();
      chk("t5_idle_wb", int'(wb_valid), 0);
      chk("t5_idle_busy", int'(busy), 0);
      chk("t5_idle_ready", int'(cmd_ready), 1);
      inj_feed_req++;
      push_cmd(1);
      send(1);
      wait_idle(200, "t5_finish");
      chk("t5_wb_count", n_wb - w0, 3);
      q_empty("t5");

      // 6: projection unit never answers
      drop_out = 1'b1;
`ifdef PROJ_TIMEOUT_EN
      rd_q.push_back(0);
      done_q.push_back(1);
      send(2);
      wait_inv(1, "t6_reach_feed");
      k = 0;
      while (!done && k < 40) begin
         tick();
         k++;
      end
      chk("t6_tmo_done_cycle", k, 17);
      chk("t6_tmo_err", int'(err), 1);
      drop_out = 1'b0;
      tick();
      chk("t6_err_sticky", int'(err), 1);
      push_cmd(1);
      send(1);
      chk("t6_err_cleared", int'(err), 0);
      wait_idle(200, "t6_finish");
      q_empty("t6");
`else
      rd_q.push_back(0);
      send(2);
      wait_inv(1, "t6_reach_feed");
      tick();
      bad = 0;
      repeat (100) begin
         tick();
         if (!busy || done || wb_valid) bad++;
      end
      chk("t6_wait_forever", bad, 0);
      chk("t6_err_tied", int'(err), 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      drop_out = 1'b0;
      chk("t6_abort_idle", int'(busy), 0);
      repeat (2) tick();
      q_empty("t6");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
